// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a byte-wide register memory.
// It inserts fixed PREADY wait states, reports out-of-range addresses on PSLVERR, and counts those error responses.
module apb_slave_mem #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 192,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [7:0]        err_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [3:0]        cnt_q;
  logic              ready_q;
  logic              slverr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        errcnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              setup_err_d;
  logic [DATA_W-1:0] setup_rdata_d;
  logic [DATA_W-1:0] acc_rdata_d;

  // The extra MSB keeps the range check correct when DEPTH == 2**ADDR_W.
  assign setup_err_d   = ({1'b0, PADDR} >= (ADDR_W+1)'(DEPTH));
  assign setup_rdata_d = (!PWRITE && !setup_err_d) ? mem_q[PADDR[IDX_W-1:0]] : '0;
  assign acc_rdata_d   = (!wr_q && !err_q) ? mem_q[addr_q[IDX_W-1:0]] : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
      errcnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (PSEL && !PENABLE) begin
      // A setup phase is taken from either state; one seen in ACCESS drops the old transfer.
      state_q <= ACCESS;
      addr_q  <= PADDR;
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
      err_q   <= setup_err_d;
      if (WAIT_CYCLES == 0) begin
        ready_q  <= 1'b1;
        slverr_q <= setup_err_d;
        rdata_q  <= setup_rdata_d;
        cnt_q    <= '0;
      end else begin
        ready_q  <= 1'b0;
        slverr_q <= 1'b0;
        rdata_q  <= '0;
        cnt_q    <= 4'(WAIT_CYCLES);
      end
    end else if (state_q == ACCESS) begin
      if (!PSEL) begin
        state_q  <= IDLE;
        ready_q  <= 1'b0;
        slverr_q <= 1'b0;
        rdata_q  <= '0;
      end else if (!ready_q) begin
        if (cnt_q > 4'd1) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          ready_q  <= 1'b1;
          slverr_q <= err_q;
          rdata_q  <= acc_rdata_d;
        end
      end else begin
        if (wr_q && !err_q) mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
        if (err_q && (errcnt_q != 8'hFF)) errcnt_q <= errcnt_q + 8'd1;
        state_q  <= IDLE;
        ready_q  <= 1'b0;
        slverr_q <= 1'b0;
        rdata_q  <= '0;
      end
    end
  end

  assign PRDATA    = rdata_q;
  assign PREADY    = ready_q;
  assign PSLVERR   = slverr_q;
  assign err_count = errcnt_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem.
// It drives a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance, which share the bus and have separate selects.
module tb_apb_slave_mem;
  logic       PCLK = 1'b0, PRESET = 1'b1;
  logic       PSEL = 1'b0, PSEL0 = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0] PADDR = 8'h00, PWDATA = 8'h00;
  logic [7:0] PRDATA, PRDATA0, ec, ec0;
  logic       PREADY, PREADY0, PSLVERR, PSLVERR0;
  bit         use0 = 1'b0;
  int         total = 0, passed = 0, cyc = 0;

  apb_slave_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(192), .WAIT_CYCLES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .err_count(ec));

  apb_slave_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(192), .WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA0), .PREADY(PREADY0),
    .PSLVERR(PSLVERR0), .err_count(ec0));

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  logic       rdy_m, err_m;
  logic [7:0] rd_m, ec_m;
  assign rdy_m = use0 ? PREADY0   : PREADY;
  assign err_m = use0 ? PSLVERR0  : PSLVERR;
  assign rd_m  = use0 ? PRDATA0   : PRDATA;
  assign ec_m  = use0 ? ec0       : ec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full transfer: setup, then access until PREADY, then the completion edge.
  // PADDR/PWDATA are scrambled after setup so the latched copies must be used.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic se, output int acc);
    PWRITE = wr; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    if (use0) PSEL0 = 1'b1; else PSEL = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PADDR = ~a; PWDATA = ~d;
    acc = 1;
    while (!rdy_m && acc < 20) begin
      @(posedge PCLK); #1;
      acc++;
    end
    rd = rd_m; se = err_m;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PSEL0 = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       se;
    int         acc, t0, n;

    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_errcnt", ec, 0);
    chk("rst_pready0", PREADY0, 0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Basic write then read, with wait-state timing.
    xfer(1, 8'h10, 8'hA5, rd, se, acc);
    chk("wr10_acc", acc, 3);
    chk("wr10_err", se, 0);
    xfer(0, 8'h10, 8'h00, rd, se, acc);
    chk("rd10_acc", acc, 3);
    chk("rd10_data", rd, 8'hA5);
    chk("rd10_err", se, 0);

    // Out-of-range accesses.
    xfer(0, 8'hC0, 8'h00, rd, se, acc);
    chk("rdC0_err", se, 1);
    chk("rdC0_data", rd, 0);
    chk("rdC0_errcnt", ec, 1);
    xfer(1, 8'hC5, 8'h33, rd, se, acc);
    chk("wrC5_err", se, 1);
    chk("wrC5_errcnt", ec, 2);
    xfer(0, 8'h05, 8'h00, rd, se, acc);
    chk("rd05_noalias", rd, 0);
    chk("rd05_err", se, 0);

    // Back-to-back transfers, 4 cycles each with no idle cycles.
    t0 = cyc;
    xfer(1, 8'h01, 8'h11, rd, se, acc);
    chk("b2b_wr1_acc", acc, 3);
    xfer(1, 8'h02, 8'h22, rd, se, acc);
    chk("b2b_wr2_acc", acc, 3);
    xfer(0, 8'h01, 8'h00, rd, se, acc);
    chk("b2b_rd1", rd, 8'h11);
    xfer(0, 8'h02, 8'h00, rd, se, acc);
    chk("b2b_rd2", rd, 8'h22);
    chk("b2b_cycles", cyc - t0, 16);

    // Abort by dropping PSEL after one access cycle.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h20; PWDATA = 8'h77;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("abort_wait_rdy", PREADY, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("abort_rdy", PREADY, 0);
    @(posedge PCLK); #1;
    chk("abort_idle_rdy", PREADY, 0);
    chk("abort_errcnt", ec, 2);
    xfer(0, 8'h20, 8'h00, rd, se, acc);
    chk("abort_rd20", rd, 0);

    // New setup during ACCESS restarts the transfer; the abandoned write is dropped.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h30; PWDATA = 8'h44;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    xfer(1, 8'h31, 8'h55, rd, se, acc);
    chk("resetup_acc", acc, 3);
    xfer(0, 8'h30, 8'h00, rd, se, acc);
    chk("resetup_rd30", rd, 0);
    xfer(0, 8'h31, 8'h00, rd, se, acc);
    chk("resetup_rd31", rd, 8'h55);

    // Reset during the wait states of a write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 8'h5A;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("midrst_pready", PREADY, 0);
    chk("midrst_pslverr", PSLVERR, 0);
    chk("midrst_prdata", PRDATA, 0);
    chk("midrst_errcnt", ec, 0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    xfer(0, 8'h08, 8'h00, rd, se, acc);
    chk("midrst_rd08", rd, 0);
    xfer(0, 8'h31, 8'h00, rd, se, acc);
    chk("midrst_memclr", rd, 0);

    // Reset coinciding with the completion edge suppresses the write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h09; PWDATA = 8'h5A;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    while (!PREADY && n < 20) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk("cplrst_reached", PREADY, 1);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("cplrst_pready", PREADY, 0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    xfer(0, 8'h09, 8'h00, rd, se, acc);
    chk("cplrst_rd09", rd, 0);

    // err_count saturation.
    for (int i = 0; i < 254; i++) xfer(0, 8'hFF, 8'h00, rd, se, acc);
    chk("sat_254", ec, 254);
    xfer(0, 8'hFF, 8'h00, rd, se, acc);
    chk("sat_255", ec, 255);
    for (int i = 0; i < 45; i++) xfer(0, 8'hFF, 8'h00, rd, se, acc);
    chk("sat_hold", ec, 255);

    // Zero-wait instance.
    use0 = 1'b1;
    xfer(1, 8'h04, 8'h3C, rd, se, acc);
    chk("w0_wr_acc", acc, 1);
    chk("w0_wr_err", se, 0);
    xfer(0, 8'h04, 8'h00, rd, se, acc);
    chk("w0_rd_acc", acc, 1);
    chk("w0_rd_data", rd, 8'h3C);
    xfer(0, 8'hC0, 8'h00, rd, se, acc);
    chk("w0_err", se, 1);
    chk("w0_err_data", rd, 0);
    chk("w0_errcnt", ec_m, 1);
    use0 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer that answers the transfers issued by the team's APB master bridge.
- Holds a byte-wide register memory, inserts a fixed number of PREADY wait states, and flags out-of-range accesses with PSLVERR.
- Sits on the APB side of the bridge, one instance per slave select, and counts error responses for debug.

Parameters:
DATA_W, 8, data bus width (PWDATA/PRDATA)
ADDR_W, 8, address width (PADDR)
DEPTH, 192, number of memory locations; legal addresses are 0..DEPTH-1; DEPTH <= 2**ADDR_W
WAIT_CYCLES, 2, PREADY-low access cycles before completion; legal range 0..15

Ports:
PCLK  input  1  clock, all logic on rising edge
PRESET  input  1  synchronous active-high reset
PSEL  input  1  slave select from master
PENABLE  input  1  access phase indicator
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_W  transfer address
PWDATA  input  DATA_W  write data
PRDATA  output  DATA_W  read data, valid only while PREADY=1 on a read
PREADY  output  1  transfer completion
PSLVERR  output  1  error response, valid only while PREADY=1
err_count  output  8  saturating count of PSLVERR responses

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - state<=IDLE; PREADY, PSLVERR, PRDATA and err_count <= 0.
  - All DEPTH memory locations cleared to 0.
  - Any transfer in flight is aborted with no write.
- All outputs are registered.
- State IDLE:
  - At an edge with PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE and PWDATA; compute err = (latched addr >= DEPTH); go to ACCESS.
  - If WAIT_CYCLES=0 at that edge: PREADY<=1, PSLVERR<=err, PRDATA <= (read && !err) ? mem[addr] : 0.
  - Otherwise at that edge: PREADY<=0, wait counter cnt<=WAIT_CYCLES.
  - PENABLE=1 while in IDLE with no preceding setup is ignored; outputs stay 0.
- State ACCESS, each edge with PSEL=1 and PENABLE=1:
  - PREADY=0 and cnt>1: cnt<=cnt-1.
  - PREADY=0 and cnt==1: PREADY<=1, PSLVERR<=err, PRDATA loaded as in IDLE.
  - PREADY=1 (completion edge):
    - Write && !err: mem[addr]<=latched PWDATA.
    - Error writes leave memory unchanged.
    - If err: err_count<=err_count+1, saturating at 255.
    - PREADY, PSLVERR and PRDATA <= 0; state<=IDLE.
- Timing:
  - PREADY is high in exactly one cycle: access cycle number WAIT_CYCLES+1.
  - Total transfer = setup + WAIT_CYCLES + 1 cycles.
- Reads never modify memory. PADDR/PWDATA changes during ACCESS are ignored; the values captured at setup are used.
- PSEL=0 at any edge in ACCESS: abort. No write, no err_count increment, outputs <= 0, state<=IDLE.
- PSEL=1 with PENABLE=0 in ACCESS (protocol violation): treated as a new setup. Re-latch, restart wait count, no write for the abandoned transfer.
- Back-to-back: a setup phase in the cycle right after the completion edge is accepted from IDLE. There is no dead cycle beyond the APB setup phase.
- Simultaneous PRESET and a completion edge: reset wins; no write.

Test Plan:
- Write 0xA5 to addr 0x10 (WAIT_CYCLES=2), then read 0x10 -> PREADY low 2 access cycles, high on the 3rd; read gives PRDATA=0xA5 with PSLVERR=0.
- Read addr 0xC0 (=DEPTH) -> PSLVERR=1 and PRDATA=0 in the PREADY cycle; err_count 0->1. Write 0x33 to 0xC5 -> PSLVERR=1, err_count=2; reading 0x05 afterwards returns 0x00 (no alias).
- Back-to-back: write 0x11 to 0x01, write 0x22 to 0x02, read 0x01, read 0x02 with no idle cycles -> each takes 4 cycles; reads return 0x11 then 0x22.
- Abort: write 0x77 to 0x20, drop PSEL after 1 access cycle; then read 0x20 -> PRDATA=0x00, PREADY never went high during the aborted transfer.
- Reset mid-access: assert PRESET during the wait of a write of 0x5A to 0x08 -> all outputs 0 next cycle; later read of 0x08 = 0x00. 300 error transfers -> err_count saturates at 255.
- WAIT_CYCLES=0 build: write 0x3C to 0x04, read back -> PREADY high in the first access cycle, PRDATA=0x3C.
